// File: rtl/fifo_pixel_reader.sv
// Read-side FIFO consumer: assembles three DATA_WIDTH nibbles into an RGB pixel for VGA.
// Optional test-pattern source is enabled by defining FIFO_PIXEL_READER_TESTPAT_EN.
module fifo_pixel_reader #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    frame_start,
  input  logic                    pix_req,
  output logic [3*DATA_WIDTH-1:0] pix_out,
  output logic                    pix_valid,
`ifdef FIFO_PIXEL_READER_TESTPAT_EN
  input  logic                    tp_en,
`endif
  output logic [CNT_WIDTH-1:0]    underflow_cnt
);

  localparam int unsigned PixW = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [1:0]            asm_cnt_q, asm_cnt_d;
  logic                  inflight_q;
  logic [PixW-1:0]       asm_q, asm_d;
  logic [PixW-1:0]       buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [PixW-1:0]       pix_out_q, pix_out_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [CNT_WIDTH-1:0]  ucnt_q, ucnt_d;

  logic            run, active, tp_active, src_valid;
  logic [PixW-1:0] src_pix;
  logic            deliver, underflow_hit, buf_take, transfer, write_nib;
  logic [2:0]      pending;

`ifdef FIFO_PIXEL_READER_TESTPAT_EN
  logic [PixW-1:0] ramp_q, ramp_d;

  assign tp_active = tp_en;
  assign src_valid = tp_en ? 1'b1 : buf_valid_q;
  assign src_pix   = tp_en ? ramp_q : buf_q;

  always_comb begin
    ramp_d = ramp_q;
    if (frame_start) begin
      ramp_d = '0;
    end else if (deliver && tp_en) begin
      ramp_d = ramp_q + 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end
`else
  assign tp_active = 1'b0;
  assign src_valid = buf_valid_q;
  assign src_pix   = buf_q;
`endif

  assign run     = (state_q == StRun);
  assign active  = run && !frame_start;
  // Nibbles already assembled plus the one returning must leave room for the next read.
  assign pending = {1'b0, asm_cnt_q} + {2'b00, inflight_q};

  assign fifo_rd_en    = active && !tp_active && !fifo_empty && (pending < 3'd3);
  assign deliver       = active && pix_req && src_valid;
  assign underflow_hit = active && pix_req && !src_valid;
  assign buf_take      = deliver && !tp_active;
  assign transfer      = active && (asm_cnt_q == 2'd3) && (!buf_valid_q || buf_take);
  assign write_nib     = active && inflight_q;

  always_comb begin
    state_d     = state_q;
    asm_cnt_d   = asm_cnt_q;
    asm_d       = asm_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = 1'b0;
    ucnt_d      = ucnt_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) state_d = StRun;
      end
      StRun: begin
        if (frame_start && inflight_q) state_d = StFlush;
      end
      StFlush: begin
        state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (write_nib) begin
      unique case (asm_cnt_q)
        2'd0:    asm_d[3*DATA_WIDTH-1:2*DATA_WIDTH] = fifo_data;
        2'd1:    asm_d[2*DATA_WIDTH-1:DATA_WIDTH]   = fifo_data;
        default: asm_d[DATA_WIDTH-1:0]              = fifo_data;
      endcase
      asm_cnt_d = asm_cnt_q + 2'd1;
    end

    if (transfer) begin
      buf_d     = asm_q;
      asm_cnt_d = 2'd0;
    end

    if (transfer) begin
      buf_valid_d = 1'b1;
    end else if (buf_take) begin
      buf_valid_d = 1'b0;
    end

    // A frame boundary drops any partial or buffered pixel from the previous frame.
    if (run && frame_start) begin
      asm_cnt_d   = 2'd0;
      buf_valid_d = 1'b0;
    end

    if (deliver) begin
      pix_out_d   = src_pix;
      pix_valid_d = 1'b1;
    end else if (underflow_hit) begin
      pix_out_d = '0;
      if (ucnt_q != {CNT_WIDTH{1'b1}}) ucnt_d = ucnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= StIdle;
      asm_cnt_q   <= 2'd0;
      inflight_q  <= 1'b0;
      asm_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      asm_cnt_q   <= asm_cnt_d;
      inflight_q  <= fifo_rd_en;
      asm_q       <= asm_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign pix_out       = pix_out_q;
  assign pix_valid     = pix_valid_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Directed bench for fifo_pixel_reader with a behavioural 1-cycle-latency FIFO model.
// Define FIFO_PIXEL_READER_TESTPAT_EN to also exercise the test-pattern source.
module tb_fifo_pixel_reader;

  localparam int DW = 4;
  localparam int CW = 3;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          frame_start;
  logic          pix_req;
  logic [3*DW-1:0] pix_out;
  logic          pix_valid;
  logic [CW-1:0] underflow_cnt;
`ifdef FIFO_PIXEL_READER_TESTPAT_EN
  logic          tp_en;
`endif

  fifo_pixel_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data     (fifo_data),
    .frame_start   (frame_start),
    .pix_req       (pix_req),
    .pix_out       (pix_out),
    .pix_valid     (pix_valid),
`ifdef FIFO_PIXEL_READER_TESTPAT_EN
    .tp_en         (tp_en),
`endif
    .underflow_cnt (underflow_cnt)
  );

  always #5 rclk = ~rclk;

  // FIFO model: writes only from the stimulus block, reads only from the clocked block.
  logic [DW-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int empty_rd = 0;
  int valid_cnt = 0;
  logic [3*DW-1:0] pix_log [$];

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) begin
        empty_rd <= empty_rd + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  always @(negedge rclk) begin
    if (pix_valid) begin
      pix_log.push_back(pix_out);
      valid_cnt = valid_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge rclk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic req_pulse(input int gap);
    pix_req = 1'b1;
    tick(1);
    pix_req = 1'b0;
    tick(gap);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < pix_log.size()) return 32'(pix_log[i]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    rrst_n      = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
`ifdef FIFO_PIXEL_READER_TESTPAT_EN
    tp_en       = 1'b0;
`endif
    tick(2);
    check("rst_pix_out", 32'(pix_out), 32'h0);
    check("rst_pix_valid", 32'(pix_valid), 32'h0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("rst_ucnt", 32'(underflow_cnt), 32'h0);
    rrst_n = 1'b1;
    tick(1);

    // Requests before the first frame are ignored and the FIFO is left alone.
    push(4'hA); push(4'hB); push(4'hC);
    pix_req = 1'b1;
    tick(3);
    pix_req = 1'b0;
    tick(2);
    check("idle_reads", 32'(rd_cnt), 32'd0);
    check("idle_valid", 32'(valid_cnt), 32'd0);
    check("idle_ucnt", 32'(underflow_cnt), 32'd0);

    // First pixel.
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(8);
    req_pulse(0);
    check("p0_valid", 32'(pix_valid), 32'h1);
    check("p0_pix", 32'(pix_out), 32'hABC);
    tick(1);
    check("p0_pulse", 32'(pix_valid), 32'h0);
    check("p0_reads", 32'(rd_cnt), 32'd3);
    check("p0_ucnt", 32'(underflow_cnt), 32'd0);

    // Three pixels back to back at one request per three cycles.
    for (int i = 1; i <= 9; i++) push(DW'(i));
    tick(10);
    for (int i = 0; i < 3; i++) req_pulse(2);
    check("stream_cnt", 32'(valid_cnt), 32'd4);
    check("stream_p1", log_at(1), 32'h123);
    check("stream_p2", log_at(2), 32'h456);
    check("stream_p3", log_at(3), 32'h789);
    check("stream_ucnt", 32'(underflow_cnt), 32'd0);
    tick(5);
    check("drain_reads", 32'(rd_cnt), 32'd12);
    check("drain_rd_en", 32'(fifo_rd_en), 32'h0);

    // Starved requests count underflows and zero the pixel.
    for (int i = 0; i < 5; i++) req_pulse(1);
    check("uf_valid", 32'(valid_cnt), 32'd4);
    check("uf_ucnt", 32'(underflow_cnt), 32'd5);
    check("uf_pix", 32'(pix_out), 32'h0);

    // Frame boundary with a read in flight: one FLUSH cycle, partial pixel dropped.
    push(4'h1); push(4'h2); push(4'h3);
    tick(3);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    push(4'h4); push(4'h5); push(4'h6);
    check("flush_no_rd", 32'(fifo_rd_en), 32'h0);
    tick(1);
    check("flush_resume_rd", 32'(fifo_rd_en), 32'h1);
    tick(10);
    req_pulse(1);
    check("flush_cnt", 32'(valid_cnt), 32'd5);
    check("flush_pix", log_at(4), 32'h456);
    check("flush_reads", 32'(rd_cnt), 32'd18);
    check("flush_ucnt", 32'(underflow_cnt), 32'd5);

    // frame_start beats pix_req, and clears the buffered pixel.
    push(4'h7); push(4'h8); push(4'h9);
    tick(8);
    frame_start = 1'b1;
    pix_req     = 1'b1;
    tick(1);
    frame_start = 1'b0;
    pix_req     = 1'b0;
    tick(1);
    check("prio_valid", 32'(valid_cnt), 32'd5);
    check("prio_ucnt", 32'(underflow_cnt), 32'd5);
    req_pulse(1);
    check("prio_buf_cleared", 32'(underflow_cnt), 32'd6);

    // Counter saturates at all-ones.
    for (int i = 0; i < 3; i++) req_pulse(1);
    check("sat_ucnt", 32'(underflow_cnt), 32'd7);

`ifdef FIFO_PIXEL_READER_TESTPAT_EN
    begin
      int rd_snap;
      int v_snap;
      push(4'h1); push(4'h2); push(4'h3);
      tp_en = 1'b1;
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      rd_snap = rd_cnt;
      v_snap  = valid_cnt;
      for (int i = 0; i < 4; i++) req_pulse(2);
      check("tp_cnt", 32'(valid_cnt - v_snap), 32'd4);
      for (int i = 0; i < 4; i++) check("tp_pix", log_at(v_snap + i), 32'(i));
      check("tp_no_reads", 32'(rd_cnt - rd_snap), 32'd0);
      tp_en = 1'b0;
    end
`endif

    check("never_rd_empty", 32'(empty_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
